branch_predictor_bht: RTL
=========================

// Module: branch_predictor_bht
// PURPOSE
//  Parametrised fetch-stage predictor for the RISC-V pipeline.
//  - Per-PC table of saturating counters (BHT) predicts conditional branches.
//  - Direct-mapped BTB predicts JALR targets; JAL targets are computed in fetch.
//  - Execute-stage resolution trains both tables and raises redirect/flush on mispredict.
//  - Sits between the PC register (drives pc_next) and the F/D and D/E pipeline registers (drives flushes).
// PARAMETERS
//  XLEN        32  address/data width
//  BHT_ENTRIES 64  counter-table depth, power of 2, >=2; index = pc[$clog2(BHT_ENTRIES)+1:2]
//  CTR_BITS     2  counter width, 1..4; predict taken when counter MSB = 1
//  BTB_ENTRIES 16  BTB depth, power of 2, >=2; index = pc[$clog2(BTB_ENTRIES)+1:2]
//  TAG_W        8  BTB tag width = the TAG_W pc bits immediately above the BTB index
// PORTS
//  clk            in  1     clock, all state updates on rising edge
//  rst_n          in  1     asynchronous, active-low reset
//  f_valid        in  1     fetch slot holds a real instruction
//  f_pc           in  XLEN  fetch PC
//  f_instr        in  32    fetched instruction word
//  pred_taken     out 1     prediction for f_pc (0 when f_valid=0)
//  pred_target    out XLEN  predicted target, meaningful only when pred_taken=1
//  pc_next        out XLEN  next fetch PC
//  ex_valid       in  1     resolved control-flow instruction present in execute
//  ex_pc          in  XLEN  its PC
//  ex_is_branch   in  1     conditional branch (opcode 1100011)
//  ex_is_jalr     in  1     JALR (opcode 1100111)
//  ex_taken       in  1     actual outcome; 1 for jumps
//  ex_target      in  XLEN  actual target address
//  ex_pred_taken  in  1     prediction carried down the pipe with the instruction
//  ex_pred_target in  XLEN  target predicted at fetch, carried with it
//  redirect       out 1     mispredict this cycle
//  flush_fd       out 1     flush F/D register, equals redirect
//  flush_de       out 1     flush D/E register, equals redirect
//  n_branches     out 32    resolved conditional branches, saturates at 32'hFFFF_FFFF
//  n_mispredicts  out 32    mispredicts of every kind, saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//  Reset (rst_n=0, async)
//  - All counters = 2**(CTR_BITS-1)-1 (weakly not-taken); all BTB valid bits = 0; stats = 0.
//  - Outputs settle combinationally from the cleared state: pred_taken=0, redirect=0.
//  - Reset asserted mid-update discards that update.
//  Fetch prediction: combinational, zero latency; reads table state registered at the last edge.
//  - JAL (1101111): taken; target = f_pc + sext(J-imm {i[31],i[19:12],i[20],i[30:21],0}).
//  - Branch: taken iff BHT[idx] MSB=1; target = f_pc + sext(B-imm {i[31],i[7],i[30:25],i[11:8],0}).
//  - JALR: taken iff BTB valid & tag match; target = BTB data.
//  - Any other opcode, or f_valid=0: not taken.
//  - pc_next = redirect ? redirect_pc : pred_taken ? pred_target : f_pc+4.
//  - Adds are modulo 2**XLEN.
//  Resolution: combinational, same cycle as ex_valid.
//  - mispredict = ex_valid & (ex_pred_taken != ex_taken | (ex_taken & ex_pred_target != ex_target)).
//  - redirect_pc = ex_taken ? ex_target : ex_pc+4.
//  - redirect has priority over any fetch prediction in the same cycle.
//  Training: takes effect at the next edge.
//  - ex_valid & ex_is_branch: BHT[ex idx] +1 if taken, -1 if not, saturating at 0 and 2**CTR_BITS-1.
//  - ex_valid & ex_is_jalr: BTB[ex idx] <= {valid=1, tag, ex_target}; always overwrites.
//  - Same-index fetch read and execute write in one cycle: fetch sees the OLD value (no bypass).
//  - ex_is_branch and ex_is_jalr both 1 is illegal; assert in simulation.
//  Stats: n_branches increments on ex_valid&ex_is_branch; n_mispredicts increments on mispredict.
// STRUCTURE
//  Package bp_pkg:
//  - opcode localparams OP_JAL, OP_JALR, OP_BRANCH
//  - functions imm_j()/imm_b() returning sign-extended XLEN
//  - typedef btb_entry_t {valid, tag, target}
//  Sub-module bp_btb:
//  - parametrised direct-mapped BTB, 1 async read port and 1 write port
//  - owns the valid/tag/target arrays
// TESTING
//  1 Reset, then branch at 0x100 with f_valid -> pred_taken=0, pc_next=0x104.
//  2 Resolve the branch at 0x100 as taken twice (target 0x80) -> counter 01->10->11.
//    Next fetch of 0x100 (B-imm=-128) -> pred_taken=1, pc_next=0x80.
//  3 Four not-taken resolves from counter 11 -> saturates at 00, no underflow.
//    n_branches counts every resolve.
//  4 JALR at 0x200 with BTB miss, resolved to 0x3000 -> redirect=1, flush_fd=flush_de=1,
//    pc_next=0x3000. Refetch of 0x200 -> pred_target=0x3000.
//  5 JALR resolved at pc 0x200 and a fetch of aliasing pc 0x200+4*BTB_ENTRIES in the same cycle
//    -> the fetch sees the old entry; the next fetch of 0x200+4*BTB_ENTRIES misses on tag.
//  6 Assert rst_n low mid-run between edges -> stats=0, all counters 01 immediately.
//    Redirect mispredict counting resumes correctly after release.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-stage branch predictor: opcodes, immediate
// decoders and the BTB entry layout.
package bp_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_TAG_W = 8;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_XLEN-1:0]  target;
  } btb_entry_t;

  function automatic logic [DEF_XLEN-1:0] imm_j(input logic [31:0] instr);
    return {{(DEF_XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic logic [DEF_XLEN-1:0] imm_b(input logic [31:0] instr);
    return {{(DEF_XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer for JALR: one asynchronous read port for
// fetch, one write port for execute-stage training.
module bp_btb #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int XLEN    = 32,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rdIdx_i,
  input  logic [TAG_W-1:0] rdTag_i,
  output logic             rdHit_o,
  output logic [XLEN-1:0]  rdTarget_o,
  input  logic             wrEn_i,
  input  logic [IDX_W-1:0] wrIdx_i,
  input  logic [TAG_W-1:0] wrTag_i,
  input  logic [XLEN-1:0]  wrTarget_i
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];

  // Reads see the state from the last edge; a same-cycle write is not bypassed.
  assign rdHit_o    = valid_q[rdIdx_i] && (tag_q[rdIdx_i] == rdTag_i);
  assign rdTarget_o = target_q[rdIdx_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wrEn_i) begin
      valid_q[wrIdx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      tag_q[wrIdx_i]    <= wrTag_i;
      target_q[wrIdx_i] <= wrTarget_i;
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Fetch-stage predictor: saturating-counter BHT for branches, BTB for JALR,
// computed JAL targets, plus execute-stage mispredict redirect and statistics.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int BTB_ENTRIES = 16,
  parameter int TAG_W       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            f_valid,
  input  logic [XLEN-1:0] f_pc,
  input  logic [31:0]     f_instr,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic [XLEN-1:0] pc_next,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_is_jalr,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect,
  output logic            flush_fd,
  output logic            flush_de,
  output logic [31:0]     n_branches,
  output logic [31:0]     n_mispredicts
);

  localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);
  localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [CTR_BITS-1:0]  bht_q [BHT_ENTRIES];
  logic [CTR_BITS-1:0]  ctr_d;
  logic [31:0]          nBranches_q;
  logic [31:0]          nMispredicts_q;

  logic [BHT_IDX_W-1:0] fBhtIdx;
  logic [BHT_IDX_W-1:0] exBhtIdx;
  logic [BTB_IDX_W-1:0] fBtbIdx;
  logic [BTB_IDX_W-1:0] exBtbIdx;
  logic [TAG_W-1:0]     fBtbTag;
  logic [TAG_W-1:0]     exBtbTag;
  logic                 btbHit;
  logic [XLEN-1:0]      btbTarget;
  logic [XLEN-1:0]      immJ;
  logic [XLEN-1:0]      immB;
  logic                 mispredict;
  logic [XLEN-1:0]      redirectPc;

  assign fBhtIdx  = f_pc[BHT_IDX_W+1:2];
  assign exBhtIdx = ex_pc[BHT_IDX_W+1:2];
  assign fBtbIdx  = f_pc[BTB_IDX_W+1:2];
  assign exBtbIdx = ex_pc[BTB_IDX_W+1:2];
  assign fBtbTag  = f_pc[BTB_IDX_W+2+TAG_W-1:BTB_IDX_W+2];
  assign exBtbTag = ex_pc[BTB_IDX_W+2+TAG_W-1:BTB_IDX_W+2];

  // Package decoders produce DEF_XLEN bits; a signed size cast re-extends to XLEN.
  assign immJ = XLEN'(signed'(imm_j(f_instr)));
  assign immB = XLEN'(signed'(imm_b(f_instr)));

  bp_btb #(
    .ENTRIES(BTB_ENTRIES),
    .TAG_W  (TAG_W),
    .XLEN   (XLEN)
  ) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdIdx_i   (fBtbIdx),
    .rdTag_i   (fBtbTag),
    .rdHit_o   (btbHit),
    .rdTarget_o(btbTarget),
    .wrEn_i    (ex_valid && ex_is_jalr),
    .wrIdx_i   (exBtbIdx),
    .wrTag_i   (exBtbTag),
    .wrTarget_i(ex_target)
  );

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = '0;
    if (f_valid) begin
      case (f_instr[6:0])
        OP_JAL: begin
          pred_taken  = 1'b1;
          pred_target = f_pc + immJ;
        end
        OP_BRANCH: begin
          pred_taken  = bht_q[fBhtIdx][CTR_BITS-1];
          pred_target = f_pc + immB;
        end
        OP_JALR: begin
          pred_taken  = btbHit;
          pred_target = btbTarget;
        end
        default: begin
          pred_taken  = 1'b0;
          pred_target = '0;
        end
      endcase
    end
  end

  assign mispredict = ex_valid &&
                      ((ex_pred_taken != ex_taken) || (ex_taken && (ex_pred_target != ex_target)));
  assign redirectPc = ex_taken ? ex_target : ex_pc + XLEN'(4);
  assign redirect   = mispredict;
  assign flush_fd   = mispredict;
  assign flush_de   = mispredict;
  assign pc_next    = mispredict ? redirectPc :
                      pred_taken ? pred_target : f_pc + XLEN'(4);

  always_comb begin
    ctr_d = bht_q[exBhtIdx];
    if (ex_taken) begin
      if (bht_q[exBhtIdx] != CTR_MAX) ctr_d = bht_q[exBhtIdx] + CTR_BITS'(1);
    end else begin
      if (bht_q[exBhtIdx] != '0) ctr_d = bht_q[exBhtIdx] - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_INIT;
    end else if (ex_valid && ex_is_branch) begin
      bht_q[exBhtIdx] <= ctr_d;
    end
  end

  // Both statistics counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nBranches_q    <= '0;
      nMispredicts_q <= '0;
    end else begin
      if (ex_valid && ex_is_branch && (nBranches_q != '1)) nBranches_q <= nBranches_q + 32'd1;
      if (mispredict && (nMispredicts_q != '1)) nMispredicts_q <= nMispredicts_q + 32'd1;
    end
  end

  assign n_branches    = nBranches_q;
  assign n_mispredicts = nMispredicts_q;

  illegalExKind: assert property (@(posedge clk) disable iff (!rst_n)
                                  !(ex_valid && ex_is_branch && ex_is_jalr));

endmodule
